// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore FSM sequencing a multicycle MIPS-style datapath with a memory-wait timeout.
module multicycle_controller #(
  parameter int WAIT_LIMIT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic [1:0] pc_source,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [3:0] state,
  output logic       illegal_op,
  output logic       mem_timeout
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE,
    R_EXEC, R_WB, BRANCH, ADDI_EXEC, ADDI_WB, JUMP
  } state_e;
  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                         OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_ADDI = 6'b001000,
                         OP_J = 6'b000010;
  state_e state_q, state_d;
  logic [3:0] wait_q, wait_d;
  logic mem_st, timeout_c;
  assign state = state_q;
  always_comb begin
    state_d = state_q;
    {pc_en, pc_source, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg} = '0;
    {reg_write, alu_src_a, alu_src_b, alu_op, illegal_op, mem_timeout} = '0;
    mem_st = state_q inside {FETCH, MEM_READ, MEM_WRITE};
    timeout_c = mem_st && !mem_ready && wait_q == 4'(WAIT_LIMIT - 1);
    case (state_q)
      FETCH: begin
        mem_read = 1'b1;
        alu_src_b = 2'b01;
        ir_write = mem_ready;
        pc_en = mem_ready;
        state_d = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_LW, OP_SW:    state_d = MEM_ADDR;
          OP_R:            state_d = R_EXEC;
          OP_BEQ, OP_BNE:  state_d = BRANCH;
          OP_ADDI:         state_d = ADDI_EXEC;
          OP_J:            state_d = JUMP;
          default: begin
            illegal_op = 1'b1;
            state_d = FETCH;
          end
        endcase
      end
      MEM_ADDR, ADDI_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d = state_q == ADDI_EXEC ? ADDI_WB : opcode == OP_SW ? MEM_WRITE : MEM_READ;
      end
      MEM_READ: begin
        {mem_read, i_or_d} = 2'b11;
        state_d = mem_ready ? MEM_WB : MEM_READ;
      end
      MEM_WRITE: begin
        {mem_write, i_or_d} = 2'b11;
        state_d = mem_ready ? FETCH : MEM_WRITE;
      end
      MEM_WB: begin
        {reg_write, mem_to_reg} = 2'b11;
        state_d = FETCH;
      end
      R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op = 2'b10;
        state_d = R_WB;
      end
      R_WB: begin
        {reg_write, reg_dst} = 2'b11;
        state_d = FETCH;
      end
      ADDI_WB: begin
        reg_write = 1'b1;
        state_d = FETCH;
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_op = 2'b01;
        pc_source = 2'b01;
        pc_en = zero ^ (opcode == OP_BNE);
        state_d = FETCH;
      end
      JUMP: begin
        pc_source = 2'b10;
        pc_en = 1'b1;
        state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
    if (timeout_c) begin
      mem_timeout = 1'b1;
      state_d = FETCH;
    end
    // count only while stalled in the same memory state; a timeout restarts the count
    wait_d = (mem_st && !mem_ready && !timeout_c) ? wait_q + 4'd1 : 4'd0;
    if (rst) begin
      {pc_en, pc_source, i_or_d, mem_write, ir_write, reg_dst, mem_to_reg} = '0;
      {reg_write, alu_src_a, alu_op, illegal_op, mem_timeout} = '0;
      mem_read = 1'b1;
      alu_src_b = 2'b01;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      wait_q <= 4'd0;
    end else begin
      state_q <= state_d;
      wait_q <= wait_d;
    end
  end
endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The block SHALL have parameter WAIT_LIMIT, default 15, giving the maximum number of consecutive not-ready cycles tolerated in a memory state (range 1..15).
REQ-002 The block SHALL have these ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  reset, synchronous and active-high.
- opcode  in  6  instruction bits [31:26] from the instruction register.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completion handshake.
- pc_en  out  1  PC register enable.
- pc_source  out  2  00 ALU result, 01 ALU-out register (branch target), 10 jump target {PC[31:28], instr[25:0], 2'b00}.
- i_or_d  out  1  memory address select: 0 PC, 1 ALU-out.
- mem_read, mem_write  out  1 each  memory strobes.
- ir_write  out  1  instruction register load.
- reg_dst  out  1  0 rt, 1 rd.
- mem_to_reg  out  1  0 ALU-out, 1 memory data register.
- reg_write  out  1  register file write.
- alu_src_a  out  1  0 PC, 1 register A.
- alu_src_b  out  2  00 register B, 01 constant 4, 10 extended immediate, 11 extended immediate shifted left 2.
- alu_op  out  2  00 add, 01 subtract, 10 funct-decoded.
- state  out  4  current state encoding.
- illegal_op  out  1  unsupported opcode flag.
- mem_timeout  out  1  memory handshake timeout pulse.

Function
REQ-003 The block SHALL implement a Moore FSM with these encodings: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, R_EXEC=6, R_WB=7, BRANCH=8, ADDI_EXEC=9, ADDI_WB=10, JUMP=11; encodings 12-15 SHALL go to FETCH on the next edge with all outputs 0.
REQ-004 The block SHALL recognise these opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, bne 000101, addi 001000, j 000010.
REQ-005 Outputs SHALL be decoded per state as follows; any output not listed for a state SHALL be 0.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00, ir_write=mem_ready, pc_en=mem_ready.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00.
- MEM_ADDR / ADDI_EXEC: alu_src_a=1, alu_src_b=10, alu_op=00.
- MEM_READ: mem_read=1, i_or_d=1.
- MEM_WRITE: mem_write=1, i_or_d=1.
- MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10.
- R_WB: reg_write=1, reg_dst=1.
- ADDI_WB: reg_write=1, reg_dst=0.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01, pc_en = zero XOR (opcode==bne).
- JUMP: pc_source=10, pc_en=1.
REQ-006 Transitions SHALL be:
- FETCH->DECODE on mem_ready.
- DECODE->MEM_ADDR (lw/sw), R_EXEC, BRANCH (beq/bne), ADDI_EXEC or JUMP.
- MEM_ADDR->MEM_READ (lw) or MEM_WRITE (sw).
- MEM_READ->MEM_WB on mem_ready.
- MEM_WRITE->FETCH on mem_ready.
- R_EXEC->R_WB; ADDI_EXEC->ADDI_WB.
- MEM_WB, R_WB, ADDI_WB, BRANCH, JUMP -> FETCH.
REQ-007 In DECODE with an unrecognised opcode, illegal_op SHALL be 1 for that cycle and the next state SHALL be FETCH, with no register or memory write.
REQ-008 A 4-bit wait counter SHALL count consecutive mem_ready=0 cycles in FETCH, MEM_READ and MEM_WRITE, and SHALL clear on any state change or when mem_ready=1.
REQ-009 When mem_ready=0 and the wait counter equals WAIT_LIMIT-1, mem_timeout SHALL be 1 for that cycle and the next state SHALL be FETCH, with no ir_write, pc_en or reg_write; a FETCH timeout re-enters FETCH and retries.
REQ-010 When mem_ready=1 and the timeout condition occur in the same cycle, mem_ready SHALL win: normal transition, no mem_timeout.
REQ-011 Minimum latency SHALL be (FETCH, DECODE and memory states counted at zero wait):
- lw: 5 cycles.
- sw, R-type, addi: 4 cycles.
- beq, bne, j: 3 cycles.
Each memory wait cycle SHALL add one cycle.

Reset
REQ-012 With rst=1 at a rising edge, state SHALL become FETCH and the wait counter 0, overriding any in-progress instruction or wait.
REQ-013 While rst=1, all outputs except the FETCH decode SHALL be 0, and ir_write and pc_en SHALL be forced to 0 regardless of mem_ready.

Verification
REQ-014 lw, mem_ready always 1 -> state sequence 0,1,2,3,4,0; reg_write=1 with mem_to_reg=1 in state 4 only.
REQ-015 beq with zero=1, then bne with zero=1 -> pc_en=1 in BRANCH for beq and 0 for bne; pc_source=01 in both.
REQ-016 sw with mem_ready low 3 cycles in MEM_WRITE -> mem_write held for 4 cycles, then FETCH; no mem_timeout.
REQ-017 WAIT_LIMIT=4, mem_ready stuck 0 in MEM_READ -> mem_timeout pulses on the 4th wait cycle, then FETCH; no reg_write.
REQ-018 opcode 111111 in DECODE -> illegal_op=1 for one cycle, then FETCH; j -> pc_source=10, pc_en=1 in JUMP.
REQ-019 rst asserted during R_EXEC -> state=0 next cycle; R_WB never entered.
